// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arm_mem_pkg
// Description : Shared size encodings, state type and lane helpers for the
//               MEM-stage data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    typedef logic [0:0] state_t;

    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_READY = 1'b1;

    // Byte enables for an access of the given size starting at byte offset.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SIZE_BYTE: base = 8'h01;
            SIZE_HALF: base = 8'h03;
            SIZE_WORD: base = 8'h0F;
            default:   base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    // Low offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'b000;
            SIZE_HALF: return 3'b001;
            SIZE_WORD: return 3'b011;
            default:   return 3'b111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_pipe
// Description : Fixed-depth valid/data/error shift register for responses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_resp_pipe #(
    parameter int LATENCY    = 1,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_error,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_error
);

    logic [LATENCY-1:0]    valid_d;
    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    error_d;
    logic [LATENCY-1:0]    error_q;
    logic [DATA_WIDTH-1:0] data_d [LATENCY];
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign valid_d[s] = in_valid;
            assign error_d[s] = in_error;
            assign data_d[s]  = in_data;
        end else begin : g_tail
            assign valid_d[s] = valid_q[s-1];
            assign error_d[s] = error_q[s-1];
            assign data_d[s]  = data_q[s-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            error_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            error_q <= error_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_error = error_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_unit
// Description : Byte-addressed data memory with sized loads, lane stores,
//               range/alignment errors and a post-reset clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_unit
    import arm_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_error
);

    localparam int   BYTES   = DATA_WIDTH / 8;
    localparam int   OFF_W   = $clog2(BYTES);
    localparam int   IDX_W   = $clog2(DEPTH);
    localparam int   IDX_TOP = IDX_W + OFF_W;
    localparam int   SH_W    = $clog2(DATA_WIDTH);
    localparam logic WIDE    = (DATA_WIDTH == 64);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      clear_idx_q, clear_idx_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  w_accept;
    logic [OFF_W-1:0]      w_offset;
    logic [2:0]            w_off3;
    logic [IDX_W-1:0]      w_index;
    logic [SH_W-1:0]       w_shift;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_bad_size;
    logic                  w_error;
    logic [7:0]            w_mask8;
    logic [BYTES-1:0]      w_lanes;
    logic [DATA_WIDTH-1:0] w_rshift;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_pipe_data;

    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_idx;
    logic [BYTES-1:0]      w_mem_be;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    assign req_ready = (state_q == ST_READY);
    assign w_accept  = req_valid & req_ready;

    assign w_offset = req_address[OFF_W-1:0];
    assign w_off3   = 3'(w_offset);
    assign w_index  = req_address[IDX_TOP-1:OFF_W];
    assign w_shift  = {w_offset, 3'b000};

    if (IDX_TOP < ADDR_WIDTH) begin : g_range_chk
        assign w_out_of_range = |req_address[ADDR_WIDTH-1:IDX_TOP];
    end else begin : g_range_full
        assign w_out_of_range = 1'b0;
    end

    assign w_misaligned = |(w_off3 & align_mask(req_size));
    assign w_bad_size   = (req_size == SIZE_DWORD) & ~WIDE;
    assign w_error      = w_misaligned | w_out_of_range | w_bad_size;

    assign w_mask8 = lane_mask(req_size, w_off3);
    assign w_lanes = w_mask8[BYTES-1:0];

    // Sweep state: one word zeroed per cycle, wrapping idx back to 0 on exit.
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clear_idx_d = clear_idx_q + 1'b1;
                if (clear_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                if (clear) begin
                    state_d     = ST_CLEAR;
                    clear_idx_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clear_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_index;
        w_mem_be    = '0;
        w_mem_wdata = req_wdata << w_shift;
        if (state_q == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = clear_idx_q;
            w_mem_be    = '1;
            w_mem_wdata = '0;
        end else if (w_accept & req_write & ~w_error) begin
            w_mem_we = 1'b1;
            w_mem_be = w_lanes;
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_mem_be[b]) begin
                    mem_q[w_mem_idx][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read is combinational so the pipe head captures the lane at the accept edge.
    assign w_rshift = mem_q[w_index] >> w_shift;

    always_comb begin
        w_ext = w_rshift;
        case (req_size)
            SIZE_BYTE: w_ext = req_signed ? DATA_WIDTH'($signed(w_rshift[7:0]))
                                          : DATA_WIDTH'(w_rshift[7:0]);
            SIZE_HALF: w_ext = req_signed ? DATA_WIDTH'($signed(w_rshift[15:0]))
                                          : DATA_WIDTH'(w_rshift[15:0]);
            SIZE_WORD: w_ext = req_signed ? DATA_WIDTH'($signed(w_rshift[31:0]))
                                          : DATA_WIDTH'(w_rshift[31:0]);
            default:   w_ext = w_rshift;
        endcase
    end

    assign w_pipe_data = (w_accept & ~req_write & ~w_error) ? w_ext : '0;

    mem_resp_pipe #(
        .LATENCY    (LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (w_accept),
        .in_data   (w_pipe_data),
        .in_error  (w_accept & w_error),
        .out_valid (resp_valid),
        .out_data  (resp_data),
        .out_error (resp_error)
    );

endmodule
`default_nettype wire
